// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Brief    : Synchronize, debounce and step-pulse multi-channel push buttons,
//             with optional auto-repeat while a button is held.
//  Revision : 1.0
// ============================================================================
module button_conditioner #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 32,
    parameter int REPEAT_CYCLES = 8,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HELD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] r_hold_cnt;
        logic [1:0]       r_state;
        logic             r_level;
        logic             r_pulse;
        logic             w_mismatch;
        logic             w_accept;
        logic             w_rise;
        logic             w_fall;

        // The level flips on the edge the window completes; the FSM reacts to
        // that same edge so level and press pulse register together.
        assign w_mismatch = r_sync2[i] ^ r_level;
        assign w_accept   = w_mismatch && (r_db_cnt == c_DB_LAST);
        assign w_rise     = w_accept && !r_level;
        assign w_fall     = w_accept && r_level;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db_cnt <= '0;
                r_level  <= 1'b0;
            end else if (!w_mismatch) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt <= '0;
                r_level  <= ~r_level;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state    <= c_ST_IDLE;
                r_hold_cnt <= '0;
                r_pulse    <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                case (r_state)
                    c_ST_IDLE: begin
                        r_hold_cnt <= '0;
                        if (w_rise) begin
                            r_pulse <= 1'b1;
                            r_state <= c_ST_HELD;
                        end
                    end
                    c_ST_HELD: begin
                        if (w_fall || !r_level) begin
                            r_state    <= c_ST_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == c_HOLD_LAST) begin
                            // Without auto-repeat the counter parks here until release.
                            if (REPEAT_EN != 0) begin
                                r_pulse    <= 1'b1;
                                r_state    <= c_ST_REPEAT;
                                r_hold_cnt <= '0;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    c_ST_REPEAT: begin
                        if (w_fall || !r_level) begin
                            r_state    <= c_ST_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == c_REP_LAST) begin
                            r_pulse    <= 1'b1;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= c_ST_IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = r_level;
        assign btn_pulse[i] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Brief    : Scoreboard bench for button_conditioner (auto-repeat on and off).
//  Revision : 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int N = 4;

    typedef struct {
        int          cyc;
        logic [N-1:0] val;
    } ev_t;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] lvl0, pls0, lvl1, pls1;
    logic [N-1:0] prev_lvl = '0;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    ev_t pq0[$];
    ev_t pq1[$];
    ev_t lq[$];

    button_conditioner #(
        .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(32), .REPEAT_CYCLES(8),
        .REPEAT_EN(1), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl0), .btn_pulse(pls0)
    );

    button_conditioner #(
        .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(32), .REPEAT_CYCLES(8),
        .REPEAT_EN(0), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl1), .btn_pulse(pls1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int got_c,
                       input logic [N-1:0] got_v, input int exp_c, input logic [N-1:0] exp_v);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got cyc=%0d val=%b, required cyc=%0d val=%b",
                      name, got_c, got_v, exp_c, exp_v);
    endtask

    // Press pulses go to both instances; repeat pulses only to the repeating one.
    task automatic push_p(input int c, input logic [N-1:0] m, input bit both);
        ev_t e;
        e.cyc = c;
        e.val = m;
        pq0.push_back(e);
        if (both) pq1.push_back(e);
    endtask

    task automatic push_l(input int c, input logic [N-1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        lq.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t e;
        while (pq0.size() > 0 && pq0[0].cyc < cyc) begin
            e = pq0.pop_front();
            chk(1'b0, "pulse0_missing", cyc, pls0, e.cyc, e.val);
        end
        if (pls0 != '0) begin
            if (pq0.size() > 0 && pq0[0].cyc == cyc) begin
                e = pq0.pop_front();
                chk(pls0 == e.val, "pulse0", cyc, pls0, e.cyc, e.val);
            end else begin
                chk(1'b0, "pulse0_unexpected", cyc, pls0, -1, '0);
            end
        end

        while (pq1.size() > 0 && pq1[0].cyc < cyc) begin
            e = pq1.pop_front();
            chk(1'b0, "pulse1_missing", cyc, pls1, e.cyc, e.val);
        end
        if (pls1 != '0) begin
            if (pq1.size() > 0 && pq1[0].cyc == cyc) begin
                e = pq1.pop_front();
                chk(pls1 == e.val, "pulse1_norepeat", cyc, pls1, e.cyc, e.val);
            end else begin
                chk(1'b0, "pulse1_unexpected", cyc, pls1, -1, '0);
            end
        end

        while (lq.size() > 0 && lq[0].cyc < cyc) begin
            e = lq.pop_front();
            chk(1'b0, "level_missing", cyc, lvl0, e.cyc, e.val);
        end
        if (lvl0 != prev_lvl) begin
            if (lq.size() > 0 && lq[0].cyc == cyc) begin
                e = lq.pop_front();
                chk(lvl0 == e.val, "level", cyc, lvl0, e.cyc, e.val);
            end else begin
                chk(1'b0, "level_unexpected", cyc, lvl0, -1, prev_lvl);
            end
        end
        prev_lvl <= lvl0;
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(lvl0 == '0, "reset_level0", cyc, lvl0, cyc, '0);
        chk(pls0 == '0, "reset_pulse0", cyc, pls0, cyc, '0);
        chk(lvl1 == '0, "reset_level1", cyc, lvl1, cyc, '0);
        chk(pls1 == '0, "reset_pulse1", cyc, pls1, cyc, '0);
        rst = 1'b1;

        // Clean press on ch0, released before the first repeat is due.
        wait_to(20);
        btn_raw[0] = 1'b1;
        push_p(26, 4'b0001, 1'b1);
        push_l(26, 4'b0001);
        wait_to(50);
        btn_raw[0] = 1'b0;
        push_l(56, 4'b0000);

        // Bounce on ch1, then a stable rise at 88.
        wait_to(80);  btn_raw[1] = 1'b1;
        wait_to(82);  btn_raw[1] = 1'b0;
        wait_to(84);  btn_raw[1] = 1'b1;
        wait_to(86);  btn_raw[1] = 1'b0;
        wait_to(88);  btn_raw[1] = 1'b1;
        push_p(94, 4'b0010, 1'b1);
        push_l(94, 4'b0010);
        wait_to(110); btn_raw[1] = 1'b0;
        push_l(116, 4'b0000);

        // Three-cycle glitch: nothing expected.
        wait_to(130); btn_raw[1] = 1'b1;
        wait_to(133); btn_raw[1] = 1'b0;

        // Auto-repeat on ch2: press at 156, repeats 188..252 every 8.
        wait_to(150);
        btn_raw[2] = 1'b1;
        push_p(156, 4'b0100, 1'b1);
        for (int i = 0; i < 9; i++) push_p(188 + 8 * i, 4'b0100, 1'b0);
        push_l(156, 4'b0100);
        wait_to(251);
        btn_raw[2] = 1'b0;
        push_l(257, 4'b0000);

        // Simultaneous ch0/ch1 press, independent releases.
        wait_to(280);
        btn_raw[1:0] = 2'b11;
        push_p(286, 4'b0011, 1'b1);
        push_l(286, 4'b0011);
        wait_to(300); btn_raw[0] = 1'b0;
        push_l(306, 4'b0010);
        wait_to(310); btn_raw[1] = 1'b0;
        push_l(316, 4'b0000);

        // Reset while ch3 is repeating, button held through reset release.
        wait_to(330);
        btn_raw[3] = 1'b1;
        push_p(336, 4'b1000, 1'b1);
        push_p(368, 4'b1000, 1'b0);
        push_l(336, 4'b1000);
        wait_to(372);
        #2 rst = 1'b0;
        push_l(373, 4'b0000);
        #1;
        chk(lvl0 == '0, "midreset_level0", cyc, lvl0, cyc, '0);
        chk(pls0 == '0, "midreset_pulse0", cyc, pls0, cyc, '0);
        chk(lvl1 == '0, "midreset_level1", cyc, lvl1, cyc, '0);
        wait_to(380);
        rst = 1'b1;
        push_p(386, 4'b1000, 1'b1);
        push_p(418, 4'b1000, 1'b0);
        push_l(386, 4'b1000);
        wait_to(415);
        btn_raw[3] = 1'b0;
        push_l(421, 4'b0000);

        wait_to(440);
        chk(pq0.size() == 0, "pulse0_drained", cyc, 4'(pq0.size()), cyc, '0);
        chk(pq1.size() == 0, "pulse1_drained", cyc, 4'(pq1.size()), cyc, '0);
        chk(lq.size() == 0, "level_drained", cyc, 4'(lq.size()), cyc, '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
